// File: rtl/lzc_pipe.sv
// Two-stage elastic leading-zero counter: stage 1 nibble counts, stage 2 boundary-encoder tree.
// Define LZC_NORM_EN to also register the normalised operand on o_norm.
module lzc_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero,
  output logic [TAG_W-1:0] o_tag,
  output logic [WIDTH-1:0] o_norm
);

  localparam int NN = WIDTH / 4;
  localparam int LV = $clog2(NN);
  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 8 || WIDTH > 128 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("lzc_pipe: WIDTH must be a power of 2 in 8..128");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("lzc_pipe: TAG_W must be >= 1");
  end

  function automatic logic [1:0] lz2(input logic [3:0] n);
    casez (n)
      4'b1???: lz2 = 2'd0;
      4'b01??: lz2 = 2'd1;
      4'b001?: lz2 = 2'd2;
      default: lz2 = 2'd3;
    endcase
  endfunction

  logic                v1, v2, adv1, adv2;
  logic [NN-1:0]       nz, z1;
  logic [NN-1:0][1:0]  nc, c1;
  logic [TAG_W-1:0]    tag1;
  logic [CNT_W-1:0]    cnt_nxt;
  logic                zero_nxt;

  assign adv2    = ~v2 | i_ready;
  assign adv1    = ~v1 | adv2;
  assign o_ready = adv1;
  assign o_valid = v2;

  always_comb begin
    nz = '0;
    nc = '0;
    for (int unsigned j = 0; j < NN; j++) begin
      nz[j] = (i_data[4*j +: 4] == 4'd0);
      nc[j] = lz2(i_data[4*j +: 4]);
    end
  end

  // Heap-ordered tree: node i has hi child 2i and lo child 2i+1; leaf NN+k is the k-th nibble from the MSB.
  always_comb begin : tree
    logic [CW-1:0] tc [1:2*NN-1];
    logic          tz [1:2*NN-1];
    for (int unsigned i = 1; i < 2 * NN; i++) begin
      tc[i] = '0;
      tz[i] = 1'b0;
    end
    for (int unsigned k = 0; k < NN; k++) begin
      tz[NN+k] = z1[NN-1-k];
      tc[NN+k] = CW'(c1[NN-1-k]);
    end
    for (int unsigned l = 0; l < LV; l++) begin
      for (int unsigned i = (NN >> (l + 1)); i < (NN >> l); i++) begin
        tz[i] = tz[2*i] & tz[2*i+1];
        tc[i] = tz[2*i] ? (tc[2*i+1] | (CW'(1) << (l + 2))) : tc[2*i];
      end
    end
    zero_nxt = tz[1];
    cnt_nxt  = tz[1] ? CNT_W'(WIDTH) : {1'b0, tc[1]};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1   <= 1'b0;
      z1   <= '0;
      c1   <= '0;
      tag1 <= '0;
    end else if (adv1) begin
      v1 <= i_valid;
      if (i_valid) begin
        z1   <= nz;
        c1   <= nc;
        tag1 <= i_tag;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v2     <= 1'b0;
      o_cnt  <= '0;
      o_zero <= 1'b0;
      o_tag  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        o_cnt  <= cnt_nxt;
        o_zero <= zero_nxt;
        o_tag  <= tag1;
      end
    end
  end

`ifdef LZC_NORM_EN
  logic [WIDTH-1:0] d1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      d1     <= '0;
      o_norm <= '0;
    end else begin
      if (adv1 && i_valid) d1 <= i_data;
      // A shift by WIDTH yields zero, covering the all-zero operand.
      if (adv2 && v1) o_norm <= d1 << cnt_nxt;
    end
  end
`else
  assign o_norm = '0;
`endif

endmodule
